// File: rtl/writeback_lanes_pkg.sv
// Shared types and load-mode encoding for the multi-lane writeback stage.
// Used by writeback_lanes and writeback_lanes_load_align (optional debug build: WB_DEBUG_EN).
package writeback_lanes_pkg;

  localparam int GPR_NUM     = 5;
  localparam int SINGLE_WORD = 32;
  localparam int LOAD_SEL_W  = 11;

  localparam int LOAD_LB_BIT  = 0;
  localparam int LOAD_LBU_BIT = 1;
  localparam int LOAD_LH_BIT  = 2;
  localparam int LOAD_LHU_BIT = 3;
  localparam int LOAD_LW_BIT  = 4;
  localparam int LOAD_L0_BIT  = 5;
  localparam int LOAD_L1_BIT  = 6;
  localparam int LOAD_L2_BIT  = 7;
  localparam int LOAD_R1_BIT  = 8;
  localparam int LOAD_R2_BIT  = 9;
  localparam int LOAD_R3_BIT  = 10;

  typedef logic [GPR_NUM-1:0]     gpr_t;
  typedef logic [SINGLE_WORD-1:0] word_t;
  typedef logic [LOAD_SEL_W-1:0]  load_sel_t;

  // Everything one lane carries from MEM into writeback.
  typedef struct packed {
    gpr_t      wnum;
    word_t     final_res;
    logic      memreq;
    logic      risk;
    logic      danger;
    word_t     rtdata;
    logic [1:0] align;
    load_sel_t loadsel;
  } lane_t;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/writeback_lanes_load_align.sv
// Combinational load extractor: byte/half select with sign extension and
// LWL/LWR merges against the old rt value.
module writeback_lanes_load_align
  import writeback_lanes_pkg::*;
(
  input  logic [1:0] align_i,
  input  load_sel_t  loadsel_i,
  input  word_t      rdata_i,
  input  word_t      rtdata_i,
  output word_t      word_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{align_i, 3'b000} +: 8];
    half_sel = align_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    // NOTE: word_o gets a default first so no path leaves it unassigned (no latch).
    word_o = rdata_i;
    if      (loadsel_i[LOAD_LB_BIT])  word_o = {{24{byte_sel[7]}}, byte_sel};
    else if (loadsel_i[LOAD_LBU_BIT]) word_o = {24'h0, byte_sel};
    else if (loadsel_i[LOAD_LH_BIT])  word_o = {{16{half_sel[15]}}, half_sel};
    else if (loadsel_i[LOAD_LHU_BIT]) word_o = {16'h0, half_sel};
    else if (loadsel_i[LOAD_LW_BIT])  word_o = rdata_i;
    else if (loadsel_i[LOAD_L0_BIT])  word_o = {rdata_i[7:0],   rtdata_i[23:0]};
    else if (loadsel_i[LOAD_L1_BIT])  word_o = {rdata_i[15:0],  rtdata_i[15:0]};
    else if (loadsel_i[LOAD_L2_BIT])  word_o = {rdata_i[23:0],  rtdata_i[7:0]};
    else if (loadsel_i[LOAD_R1_BIT])  word_o = {rtdata_i[31:24], rdata_i[31:8]};
    else if (loadsel_i[LOAD_R2_BIT])  word_o = {rtdata_i[31:16], rdata_i[31:16]};
    else if (loadsel_i[LOAD_R3_BIT])  word_o = {rtdata_i[31:8],  rdata_i[31:24]};
  end

endmodule

// File: rtl/writeback_lanes.sv
// LANES-wide writeback stage: holds one bundle, buffers per-lane load data
// during stalls, and drives RF writes/forwarding. Optional debug build: WB_DEBUG_EN.
module writeback_lanes
  import writeback_lanes_pkg::*;
#(
  parameter int LANES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_valid_i,
  input  logic                       pba_ok_i,
  input  logic [LANES*5-1:0]         mem_wnum_i,
  input  logic [LANES*32-1:0]        mem_final_i,
  input  logic [LANES-1:0]           mem_memreq_i,
  input  logic [LANES*32-1:0]        mem_pc_i,
  input  logic [LANES-1:0]           mem_risk_i,
  input  logic [LANES-1:0]           mem_danger_i,
  input  logic [LANES*32-1:0]        mem_rtdata_i,
  input  logic [LANES*2-1:0]         mem_align_i,
  input  logic [LANES*LOAD_SEL_W-1:0] mem_loadsel_i,
  input  logic [LANES-1:0]           data_ok_i,
  input  logic [LANES*32-1:0]        data_rdata_i,
`ifdef WB_DEBUG_EN
  output logic [LANES*32-1:0]        debug_wb_pc_o,
  output logic [LANES*4-1:0]         debug_wb_rf_wen_o,
  output logic [LANES*5-1:0]         debug_wb_rf_wnum_o,
  output logic [LANES*32-1:0]        debug_wb_rf_wdata_o,
  output logic [31:0]                debug_commit_cnt_o,
`endif
  output logic                       wb_allowin_o,
  output logic                       wb_valid_o,
  output logic [LANES-1:0]           wb_wen_o,
  output logic [LANES*5-1:0]         wb_wnum_o,
  output logic [LANES*32-1:0]        wb_wdata_o,
  output logic [LANES*32-1:0]        wb_fwd_data_o,
  output logic [LANES-1:0]           wb_fwd_vld_o,
  output logic                       wb_has_risk_o,
  output logic                       wb_has_danger_o
);

  lane_t            lane_q [LANES];
  lane_t            lane_d [LANES];
  word_t            buf_q  [LANES];
  word_t            buf_d  [LANES];
  word_t            load_word [LANES];
  logic [LANES-1:0] got_q, got_d, resolved, waw_kill;
  logic             has_data_q, has_data_d;
  logic             leave, risk_or, danger_or;

  assign wb_valid_o   = has_data_q && (&resolved);
  assign wb_allowin_o = (!has_data_q || (&resolved)) && pba_ok_i;
  assign leave        = wb_valid_o && pba_ok_i;

  always_comb begin
    has_data_d = has_data_q;
    got_d      = got_q;
    for (int i = 0; i < LANES; i++) begin
      lane_d[i] = lane_q[i];
      buf_d[i]  = buf_q[i];
    end
    if (wb_allowin_o) begin
      // Covers leave, capture and clear: got always restarts with the slot.
      has_data_d = mem_valid_i;
      got_d      = '0;
      for (int i = 0; i < LANES; i++) begin
        buf_d[i]  = '0;
        lane_d[i] = '0;
        if (mem_valid_i) begin
          lane_d[i].wnum      = mem_wnum_i[i*GPR_NUM +: GPR_NUM];
          lane_d[i].final_res = mem_final_i[i*SINGLE_WORD +: SINGLE_WORD];
          lane_d[i].memreq    = mem_memreq_i[i];
          lane_d[i].risk      = mem_risk_i[i];
          lane_d[i].danger    = mem_danger_i[i];
          lane_d[i].rtdata    = mem_rtdata_i[i*SINGLE_WORD +: SINGLE_WORD];
          lane_d[i].align     = mem_align_i[i*2 +: 2];
          lane_d[i].loadsel   = mem_loadsel_i[i*LOAD_SEL_W +: LOAD_SEL_W];
        end
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (data_ok_i[i] && has_data_q && lane_q[i].memreq && !got_q[i]) begin
          got_d[i] = 1'b1;
          buf_d[i] = data_rdata_i[i*SINGLE_WORD +: SINGLE_WORD];
        end
      end
    end
  end

  // NOTE: the per-lane data buffers are reset like any other register so a
  // reset mid-wait can never leak a stale word into the next bundle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      has_data_q <= 1'b0;
      got_q      <= '0;
      for (int i = 0; i < LANES; i++) begin
        lane_q[i] <= '0;
        buf_q[i]  <= '0;
      end
    end else begin
      has_data_q <= has_data_d;
      got_q      <= got_d;
      for (int i = 0; i < LANES; i++) begin
        lane_q[i] <= lane_d[i];
        buf_q[i]  <= buf_d[i];
      end
    end
  end

  // Only the youngest writer of a register inside one bundle commits.
  always_comb begin
    waw_kill  = '0;
    risk_or   = 1'b0;
    danger_or = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      risk_or   = risk_or   | lane_q[i].risk;
      danger_or = danger_or | lane_q[i].danger;
      for (int j = i + 1; j < LANES; j++)
        if (lane_q[i].wnum != '0 && lane_q[j].wnum == lane_q[i].wnum) waw_kill[i] = 1'b1;
    end
  end

  assign wb_has_risk_o   = has_data_q && risk_or;
  assign wb_has_danger_o = has_data_q && danger_or;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    word_t src, lane_data;
    assign src = got_q[g] ? buf_q[g] : data_rdata_i[g*SINGLE_WORD +: SINGLE_WORD];
    writeback_lanes_load_align u_align (
      .align_i   (lane_q[g].align),
      .loadsel_i (lane_q[g].loadsel),
      .rdata_i   (src),
      .rtdata_i  (lane_q[g].rtdata),
      .word_o    (load_word[g])
    );
    assign resolved[g]  = !lane_q[g].memreq || got_q[g] || data_ok_i[g];
    assign lane_data    = lane_q[g].memreq ? load_word[g] : lane_q[g].final_res;
    assign wb_wen_o[g]  = leave && lane_q[g].wnum != '0 && !waw_kill[g];
    assign wb_wnum_o[g*GPR_NUM +: GPR_NUM]             = lane_q[g].wnum;
    assign wb_wdata_o[g*SINGLE_WORD +: SINGLE_WORD]    = lane_data;
    assign wb_fwd_data_o[g*SINGLE_WORD +: SINGLE_WORD] = lane_data;
    assign wb_fwd_vld_o[g] = has_data_q && resolved[g];
  end

`ifdef WB_DEBUG_EN
  word_t       pc_q [LANES];
  logic [3:0]  commit_mask;
  logic [31:0] commit_cnt_q;

  always_comb begin
    commit_mask = '0;
    commit_mask[LANES-1:0] = {LANES{leave && has_data_q}};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      commit_cnt_q        <= '0;
      debug_wb_pc_o       <= '0;
      debug_wb_rf_wen_o   <= '0;
      debug_wb_rf_wnum_o  <= '0;
      debug_wb_rf_wdata_o <= '0;
      for (int i = 0; i < LANES; i++) pc_q[i] <= '0;
    end else begin
      commit_cnt_q <= commit_cnt_q + 32'(popcount4(commit_mask));
      for (int i = 0; i < LANES; i++) begin
        if (wb_allowin_o) pc_q[i] <= mem_valid_i ? mem_pc_i[i*SINGLE_WORD +: SINGLE_WORD] : '0;
        debug_wb_pc_o[i*SINGLE_WORD +: SINGLE_WORD] <= pc_q[i];
        debug_wb_rf_wen_o[i*4 +: 4] <= {4{wb_wen_o[i]}};
      end
      debug_wb_rf_wnum_o  <= wb_wnum_o;
      debug_wb_rf_wdata_o <= wb_wdata_o;
    end
  end

  assign debug_commit_cnt_o = commit_cnt_q;
`else
  logic unused_pc;
  assign unused_pc = ^mem_pc_i;
`endif

endmodule

// File: tb/tb_writeback_lanes.sv
// Directed bench for writeback_lanes: expected writes are queued at issue and
// a negedge monitor pops/compares on every leave cycle.
module tb_writeback_lanes;
  import writeback_lanes_pkg::*;

  localparam int LANES = 2;
  localparam logic [10:0] SEL_LB  = 11'd1 << LOAD_LB_BIT;
  localparam logic [10:0] SEL_LBU = 11'd1 << LOAD_LBU_BIT;
  localparam logic [10:0] SEL_LW  = 11'd1 << LOAD_LW_BIT;
  localparam logic [10:0] SEL_L0  = 11'd1 << LOAD_L0_BIT;
  localparam logic [10:0] SEL_R2  = 11'd1 << LOAD_R2_BIT;

  logic clk = 1'b0;
  logic rst;
  logic mem_valid_i, pba_ok_i;
  logic [LANES*5-1:0]  mem_wnum_i;
  logic [LANES*32-1:0] mem_final_i, mem_pc_i, mem_rtdata_i, data_rdata_i;
  logic [LANES-1:0]    mem_memreq_i, mem_risk_i, mem_danger_i, data_ok_i;
  logic [LANES*2-1:0]  mem_align_i;
  logic [LANES*11-1:0] mem_loadsel_i;
  logic                wb_allowin_o, wb_valid_o, wb_has_risk_o, wb_has_danger_o;
  logic [LANES-1:0]    wb_wen_o, wb_fwd_vld_o;
  logic [LANES*5-1:0]  wb_wnum_o;
  logic [LANES*32-1:0] wb_wdata_o, wb_fwd_data_o;

  writeback_lanes #(.LANES(LANES)) dut (
    .clk(clk), .rst(rst),
    .mem_valid_i(mem_valid_i), .pba_ok_i(pba_ok_i),
    .mem_wnum_i(mem_wnum_i), .mem_final_i(mem_final_i), .mem_memreq_i(mem_memreq_i),
    .mem_pc_i(mem_pc_i), .mem_risk_i(mem_risk_i), .mem_danger_i(mem_danger_i),
    .mem_rtdata_i(mem_rtdata_i), .mem_align_i(mem_align_i), .mem_loadsel_i(mem_loadsel_i),
    .data_ok_i(data_ok_i), .data_rdata_i(data_rdata_i),
    .wb_allowin_o(wb_allowin_o), .wb_valid_o(wb_valid_o), .wb_wen_o(wb_wen_o),
    .wb_wnum_o(wb_wnum_o), .wb_wdata_o(wb_wdata_o), .wb_fwd_data_o(wb_fwd_data_o),
    .wb_fwd_vld_o(wb_fwd_vld_o), .wb_has_risk_o(wb_has_risk_o), .wb_has_danger_o(wb_has_danger_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  wen;
    logic [9:0]  wnum;
    logic [63:0] wdata;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] rf_model [32];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic expect_wb(input logic [1:0] wen, input logic [9:0] wnum,
                           input logic [63:0] wdata, input string name);
    exp_t e;
    e.wen = wen; e.wnum = wnum; e.wdata = wdata; e.name = name;
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    mem_valid_i = 1'b0; mem_wnum_i = '0; mem_final_i = '0; mem_memreq_i = '0;
    mem_pc_i = '0; mem_risk_i = '0; mem_danger_i = '0; mem_rtdata_i = '0;
    mem_align_i = '0; mem_loadsel_i = '0; data_ok_i = '0; data_rdata_i = '0;
  endtask

  task automatic set_lane(input int l, input logic [4:0] wnum, input logic [31:0] fin,
                          input logic memreq, input logic [10:0] sel,
                          input logic [1:0] al, input logic [31:0] rt);
    mem_wnum_i[l*5 +: 5]       = wnum;
    mem_final_i[l*32 +: 32]    = fin;
    mem_memreq_i[l]            = memreq;
    mem_loadsel_i[l*11 +: 11]  = sel;
    mem_align_i[l*2 +: 2]      = al;
    mem_rtdata_i[l*32 +: 32]   = rt;
    mem_pc_i[l*32 +: 32]       = 32'hBFC0_0000 + 32'(l*4);
  endtask

  // Scoreboard monitor: every cycle the bundle leaves, compare against the queue head.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && wb_valid_o && pba_ok_i) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL sb_unexpected: write wen=0x%0h with nothing expected", wb_wen_o);
        end else begin
          e = sb.pop_front();
          check({e.name, "_wen"},   64'(wb_wen_o),  64'(e.wen));
          check({e.name, "_wnum"},  64'(wb_wnum_o), 64'(e.wnum));
          check({e.name, "_wdata"}, wb_wdata_o,     e.wdata);
        end
        for (int i = 0; i < LANES; i++)
          if (wb_wen_o[i]) rf_model[wb_wnum_o[i*5 +: 5]] = wb_wdata_o[i*32 +: 32];
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    for (int r = 0; r < 32; r++) rf_model[r] = '0;
    idle_inputs();
    rst = 1'b0; pba_ok_i = 1'b0;
    repeat (3) cyc();
    sample();
    check("rst_valid",   64'(wb_valid_o),   64'h0);
    check("rst_allowin", 64'(wb_allowin_o), 64'h0);
    check("rst_wen",     64'(wb_wen_o),     64'h0);
    check("rst_wnum",    64'(wb_wnum_o),    64'h0);
    check("rst_wdata",   wb_wdata_o,        64'h0);
    check("rst_fwd_vld", 64'(wb_fwd_vld_o), 64'h0);
    check("rst_risk",    64'({wb_has_risk_o, wb_has_danger_o}), 64'h0);
    cyc(); rst = 1'b1; pba_ok_i = 1'b1;
    sample();
    check("idle_allowin", 64'(wb_allowin_o), 64'h1);

    // ALU bundle, zero added latency
    cyc();
    set_lane(0, 5'd3, 32'h11, 1'b0, '0, 2'd0, '0);
    set_lane(1, 5'd4, 32'h22, 1'b0, '0, 2'd0, '0);
    mem_risk_i = 2'b10; mem_valid_i = 1'b1;
    expect_wb(2'b11, {5'd4, 5'd3}, {32'h22, 32'h11}, "alu");
    cyc(); idle_inputs();
    sample();
    check("alu_fwd_vld",  64'(wb_fwd_vld_o), 64'h3);
    check("alu_fwd_data", wb_fwd_data_o, {32'h22, 32'h11});
    check("alu_risk",     64'({wb_has_risk_o, wb_has_danger_o}), 64'h2);

    // LB lane1, data one cycle late
    cyc();
    set_lane(1, 5'd6, '0, 1'b1, SEL_LB, 2'b10, '0); mem_valid_i = 1'b1;
    expect_wb(2'b10, {5'd6, 5'd0}, {32'hFFFF_FF80, 32'h0}, "lb");
    cyc(); idle_inputs();
    sample();
    check("lb_wait_valid",   64'(wb_valid_o),   64'h0);
    check("lb_wait_fwd_vld", 64'(wb_fwd_vld_o), 64'h1);
    check("lb_wait_allowin", 64'(wb_allowin_o), 64'h0);
    cyc(); data_ok_i = 2'b10; data_rdata_i[63:32] = 32'h0080_0000;
    sample();
    cyc(); idle_inputs();

    // LBU lane1, data in the first cycle
    set_lane(1, 5'd6, '0, 1'b1, SEL_LBU, 2'b10, '0); mem_valid_i = 1'b1;
    expect_wb(2'b10, {5'd6, 5'd0}, {32'h0000_0080, 32'h0}, "lbu");
    cyc(); idle_inputs(); data_ok_i = 2'b10; data_rdata_i[63:32] = 32'h0080_0000;
    sample();
    check("lbu_allowin", 64'(wb_allowin_o), 64'h1);
    cyc(); idle_inputs();

    // LW buffered during a 3-cycle stall; second pulse ignored
    set_lane(0, 5'd7, '0, 1'b1, SEL_LW, 2'b00, '0); mem_valid_i = 1'b1;
    expect_wb(2'b01, {5'd0, 5'd7}, {32'h0, 32'hDEAD_BEEF}, "lw_stall");
    cyc(); idle_inputs(); pba_ok_i = 1'b0; data_ok_i = 2'b01; data_rdata_i[31:0] = 32'hDEAD_BEEF;
    sample();
    check("stall1_allowin", 64'(wb_allowin_o), 64'h0);
    check("stall1_fwd_vld", 64'(wb_fwd_vld_o), 64'h3);
    cyc(); data_ok_i = 2'b00; data_rdata_i[31:0] = 32'h1234_5678;
    sample();
    check("stall2_allowin",  64'(wb_allowin_o), 64'h0);
    check("stall2_fwd_data", wb_fwd_data_o, {32'h0, 32'hDEAD_BEEF});
    check("stall2_valid",    64'(wb_valid_o), 64'h1);
    cyc(); data_ok_i = 2'b01; data_rdata_i[31:0] = 32'h0;
    sample();
    check("stall3_allowin",  64'(wb_allowin_o), 64'h0);
    check("stall3_fwd_data", wb_fwd_data_o, {32'h0, 32'hDEAD_BEEF});
    cyc(); data_ok_i = 2'b00; pba_ok_i = 1'b1;
    sample();
    check("release_allowin", 64'(wb_allowin_o), 64'h1);
    cyc(); pba_ok_i = 1'b0;
    sample();
    check("after_allowin", 64'(wb_allowin_o), 64'h0);
    check("after_valid",   64'(wb_valid_o),   64'h0);
    cyc(); pba_ok_i = 1'b1;

    // WAW: both lanes write $5, younger wins
    set_lane(0, 5'd5, 32'h1, 1'b0, '0, 2'd0, '0);
    set_lane(1, 5'd5, 32'h2, 1'b0, '0, 2'd0, '0);
    mem_valid_i = 1'b1;
    expect_wb(2'b10, {5'd5, 5'd5}, {32'h2, 32'h1}, "waw");
    cyc(); idle_inputs();
    sample();
    cyc();
    check("waw_rf5", 64'(rf_model[5]), 64'h2);

    // LWR R2 on lane0, LWL L0 on lane1
    set_lane(0, 5'd8, '0, 1'b1, SEL_R2, 2'd2, 32'h1122_3344);
    set_lane(1, 5'd9, '0, 1'b1, SEL_L0, 2'd0, 32'h1122_3344);
    mem_valid_i = 1'b1;
    expect_wb(2'b11, {5'd9, 5'd8}, {32'hDD22_3344, 32'h1122_AABB}, "lwlr");
    cyc(); idle_inputs(); data_ok_i = 2'b11; data_rdata_i = {32'hAABB_CCDD, 32'hAABB_CCDD};
    sample();
    cyc(); idle_inputs();

    // Reset while a buffered load waits; pulse in the reset cycle is dropped
    set_lane(0, 5'd10, '0, 1'b1, SEL_LW, 2'd0, '0); mem_valid_i = 1'b1;
    cyc(); idle_inputs(); pba_ok_i = 1'b0; data_ok_i = 2'b01; data_rdata_i[31:0] = 32'hCAFE_F00D;
    cyc(); rst = 1'b0; data_ok_i = 2'b01; data_rdata_i[31:0] = 32'h0BAD_BEEF;
    cyc(); rst = 1'b1; idle_inputs();
    sample();
    check("mrst_valid",    64'(wb_valid_o),    64'h0);
    check("mrst_allowin",  64'(wb_allowin_o),  64'h0);
    check("mrst_wen",      64'(wb_wen_o),      64'h0);
    check("mrst_wnum",     64'(wb_wnum_o),     64'h0);
    check("mrst_wdata",    wb_wdata_o,         64'h0);
    check("mrst_fwd_vld",  64'(wb_fwd_vld_o),  64'h0);
    check("mrst_fwd_data", wb_fwd_data_o,      64'h0);
    cyc(); pba_ok_i = 1'b1;
    set_lane(0, 5'd11, '0, 1'b1, SEL_LW, 2'd0, '0); mem_valid_i = 1'b1;
    expect_wb(2'b01, {5'd0, 5'd11}, {32'h0, 32'h1357_9BDF}, "post_rst");
    cyc(); idle_inputs();
    sample();
    check("post_rst_wait_valid", 64'(wb_valid_o),   64'h0);
    check("post_rst_fwd_vld",    64'(wb_fwd_vld_o), 64'h2);
    cyc(); data_ok_i = 2'b01; data_rdata_i[31:0] = 32'h1357_9BDF;
    sample();
    cyc(); idle_inputs();

    repeat (3) cyc();
    n_total++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL sb_drain: %0d expected writes never seen, wanted 0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
